// File: rtl/spiral_coord_gen.sv
// spiral_coord_gen: square-spiral (x,y) walk from grid centre with valid/ready output; SPIRAL_IDX_EN adds out_idx
module spiral_coord_gen #(
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_last,
  output logic               busy,
`ifdef SPIRAL_IDX_EN
  output logic [2*COORD_W-1:0] out_idx,
`endif
  output logic               done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [COORD_W-1:0] CTR  = COORD_W'(1 << (COORD_W - 1));
  localparam logic [COORD_W:0]   ONE  = (COORD_W + 1)'(1);
  localparam logic [COORD_W:0]   M1   = '1;
  localparam logic [COORD_W:0]   ZERO = '0;
  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]         dir_q, dir_d;
  logic [COORD_W:0]   len_q, len_d, step_q, step_d;
  logic               par_q, par_d;
  logic [COORD_W:0]   cx, cy, step_inc;
  logic               oob, hs, go, turn;
  // Candidate next point, one bit wider so stepping off either edge sets the top bit
  always_comb begin
    cx       = {1'b0, x_q} + (dir_q == 2'd0 ? ONE : dir_q == 2'd2 ? M1 : ZERO);
    cy       = {1'b0, y_q} + (dir_q == 2'd3 ? ONE : dir_q == 2'd1 ? M1 : ZERO);
    oob      = cx[COORD_W] | cy[COORD_W];
    hs       = (state_q == RUN) & out_ready;
    go       = (state_q != RUN) & start;
    step_inc = step_q + ONE;
    turn     = step_inc == len_q;
  end
  // Next state: start re-initialises the walk; each handshake steps or, on the final point, finishes
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    len_d   = len_q;
    step_d  = step_q;
    par_d   = par_q;
    if (go) begin
      state_d = RUN;
      x_d     = CTR;
      y_d     = CTR;
      dir_d   = 2'd0;
      len_d   = ONE;
      step_d  = ZERO;
      par_d   = 1'b0;
    end else if (hs && oob) begin
      state_d = DONE;
    end else if (hs) begin
      x_d    = cx[COORD_W-1:0];
      y_d    = cy[COORD_W-1:0];
      step_d = turn ? ZERO : step_inc;
      dir_d  = turn ? dir_q + 2'd1 : dir_q;
      par_d  = turn ? ~par_q : par_q;
      len_d  = (turn && par_q) ? len_q + ONE : len_q;
    end
  end
  // State and stepping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= CTR;
      y_q     <= CTR;
      dir_q   <= 2'd0;
      len_q   <= ONE;
      step_q  <= ZERO;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      step_q  <= step_d;
      par_q   <= par_d;
    end
  end
  // Outputs decoded from state; out_last flags a point whose successor leaves the grid
  always_comb begin
    out_valid = state_q == RUN;
    busy      = state_q == RUN;
    done      = state_q == DONE;
    out_last  = (state_q == RUN) & oob;
    out_x     = x_q;
    out_y     = y_q;
  end
`ifdef SPIRAL_IDX_EN
  logic [2*COORD_W-1:0] idx_q, idx_d;
  // Handshake counter, cleared on start
  always_comb idx_d = go ? '0 : (hs && !oob) ? idx_q + (2*COORD_W)'(1) : idx_q;
  // Index register
  always_ff @(posedge clk) idx_q <= rst ? '0 : idx_d;
  assign out_idx = idx_q;
`endif
endmodule

// File: tb/tb_spiral_coord_gen.sv
// tb_spiral_coord_gen: table vectors plus randomized-backpressure walks checked against a leg-by-leg spiral model
module tb_spiral_coord_gen;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic out_valid, out_last, busy, done;
  logic [3:0] out_x, out_y;
`ifdef SPIRAL_IDX_EN
  logic [7:0] out_idx;
`endif
  int total = 0, bad = 0;
  int rx[$], ry[$];
  typedef struct {int x; int y;} vec_t;
  vec_t first10[10];
  bit seen[16][16];

  spiral_coord_gen #(.COORD_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy),
`ifdef SPIRAL_IDX_EN
    .out_idx(out_idx),
`endif
    .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string n);
    chk({n, "_valid"}, out_valid, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_last"}, out_last, 0);
    chk({n, "_x"}, out_x, 8);
    chk({n, "_y"}, out_y, 8);
  endtask

  // Model: legs of length 1,1,2,2,... in order R,U,L,D until the next step leaves the grid
  task automatic build_ref();
    int dxs[4] = '{1, 0, -1, 0};
    int dys[4] = '{0, -1, 0, 1};
    int x = 8, y = 8, n = 0;
    bit fin = 0;
    rx.push_back(x); ry.push_back(y);
    while (!fin) begin
      for (int k = 0; k < n / 2 + 1 && !fin; k++) begin
        if (x + dxs[n % 4] < 0 || x + dxs[n % 4] > 15 || y + dys[n % 4] < 0 || y + dys[n % 4] > 15) fin = 1;
        else begin
          x += dxs[n % 4]; y += dys[n % 4];
          rx.push_back(x); ry.push_back(y);
        end
      end
      n++;
    end
  endtask

  // Start a walk, then follow it with ready asserted p percent of the time
  task automatic walk(input int p, input int mid_start, input int mid_rst);
    int i = 0, cyc = 0, uniq = 0;
    foreach (seen[a, b]) seen[a][b] = 0;
    start = 1;
    tick();
    start = 0;
    while (i < rx.size() && cyc < 5000) begin
      out_ready = ($urandom_range(0, 99) < p);
      start = (i == mid_start);
      if (i == mid_rst) begin
        rst = 1;
        tick();
        rst = 0;
        start = 0;
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
          chk_idle("midrst");
          tick();
        end
        return;
      end
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("x", out_x, rx[i]);
      chk("y", out_y, ry[i]);
      chk("last", out_last, int'(i == rx.size() - 1));
`ifdef SPIRAL_IDX_EN
      chk("idx", out_idx, i);
`endif
      if (out_ready && out_valid) begin
        if (!seen[out_x][out_y] && out_x >= 1 && out_y >= 1) uniq++;
        seen[out_x][out_y] = 1;
        i++;
      end
      tick();
      cyc++;
    end
    start = 0;
    out_ready = 0;
    chk("timeout_handshakes", i, rx.size());
    chk("unique_in_range", uniq, 225);
    chk("done_after", done, 1);
    chk("valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    first10 = '{'{8,8}, '{9,8}, '{9,7}, '{8,7}, '{7,7}, '{7,8}, '{7,9}, '{8,9}, '{9,9}, '{10,9}};
    build_ref();
    // T1 reset
    @(negedge clk);
    tick();
    chk_idle("reset");
    // rst and start together: rst wins
    start = 1;
    tick();
    start = 0;
    rst = 0;
    chk_idle("rst_start");
    // T2 first ten points from table
    start = 1;
    out_ready = 1;
    tick();
    start = 0;
    for (int k = 0; k < 10; k++) begin
      chk("t2_valid", out_valid, 1);
      chk("t2_x", out_x, first10[k].x);
      chk("t2_y", out_y, first10[k].y);
      chk("t2_last", out_last, 0);
      tick();
    end
    out_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    chk_idle("t2_rst");
    // T3 full walk, T4 backpressure, T5 mid-walk start/rst then restart, T6 restart from DONE
    walk(100, -1, -1);
    walk(50, -1, -1);
    walk(70, 50, 100);
    walk(100, -1, -1);
    walk(100, -1, -1);
    // DONE ignores out_ready and holds
    out_ready = 1;
    tick();
    chk("done_hold", done, 1);
    chk("done_valid", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
